// File: rtl/snn_spike_decoder.sv
// Output-layer readout: counts per-digit spikes over a fixed window, then scans
// the counters one index per cycle for the winning digit and offers it on valid/ready.
module snn_spike_decoder #(
  parameter int OUTPUT_SIZE   = 10,
  parameter int WINDOW_CYCLES = 100,
  parameter int CNT_WIDTH     = 8,
  parameter int IDX_WIDTH     = $clog2(OUTPUT_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [OUTPUT_SIZE-1:0] digit_spikes,
  output logic                   busy,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [IDX_WIDTH-1:0]   result_digit,
  output logic [CNT_WIDTH-1:0]   result_count,
  output logic                   result_tie,
  output logic                   result_none,
  output logic                   result_sat
);

  localparam int WIN_WIDTH = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_WIDTH-1:0] WIN_LAST = WIN_WIDTH'(WINDOW_CYCLES - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(OUTPUT_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_ARGMAX,
    S_HOLD
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q [OUTPUT_SIZE];
  logic [CNT_WIDTH-1:0]  cnt_d [OUTPUT_SIZE];
  logic [WIN_WIDTH-1:0]  win_q, win_d;
  logic                  sat_q, sat_d;
  logic [IDX_WIDTH-1:0]  scan_idx_q, scan_idx_d;
  logic [CNT_WIDTH-1:0]  max_q, max_d;
  logic [IDX_WIDTH-1:0]  best_q, best_d;
  logic                  tie_q, tie_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic [IDX_WIDTH-1:0]  res_digit_q, res_digit_d;
  logic [CNT_WIDTH-1:0]  res_count_q, res_count_d;
  logic                  res_tie_q, res_tie_d;
  logic                  res_none_q, res_none_d;
  logic                  res_sat_q, res_sat_d;

  logic [CNT_WIDTH-1:0]  cur_cnt;
  logic [CNT_WIDTH-1:0]  cand_max;
  logic [IDX_WIDTH-1:0]  cand_best;
  logic                  cand_tie;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    sat_d       = sat_q;
    scan_idx_d  = scan_idx_q;
    max_d       = max_q;
    best_d      = best_q;
    tie_d       = tie_q;
    res_digit_d = res_digit_q;
    res_count_d = res_count_q;
    res_tie_d   = res_tie_q;
    res_none_d  = res_none_q;
    res_sat_d   = res_sat_q;

    // Strict greater-than keeps the lowest index on equal counts.
    cur_cnt   = cnt_q[scan_idx_q];
    cand_max  = max_q;
    cand_best = best_q;
    cand_tie  = tie_q;
    if (cur_cnt > max_q) begin
      cand_max  = cur_cnt;
      cand_best = scan_idx_q;
      cand_tie  = 1'b0;
    end else if ((cur_cnt == max_q) && (scan_idx_q != '0)) begin
      cand_tie = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int i = 0; i < OUTPUT_SIZE; i++) cnt_d[i] = '0;
          win_d      = '0;
          sat_d      = 1'b0;
          scan_idx_d = '0;
          max_d      = '0;
          best_d     = '0;
          tie_d      = 1'b0;
          state_d    = S_ACCUM;
        end
      end
      S_ACCUM: begin
        for (int i = 0; i < OUTPUT_SIZE; i++) begin
          if (digit_spikes[i]) begin
            if (cnt_q[i] == CNT_MAX) sat_d = 1'b1;
            else cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
          end
        end
        if (win_q == WIN_LAST) state_d = S_ARGMAX;
        else win_d = win_q + WIN_WIDTH'(1);
      end
      S_ARGMAX: begin
        max_d  = cand_max;
        best_d = cand_best;
        tie_d  = cand_tie;
        if (scan_idx_q == IDX_LAST) begin
          res_none_d  = (cand_max == '0);
          res_digit_d = res_none_d ? '0 : cand_best;
          res_count_d = cand_max;
          res_tie_d   = cand_tie && !res_none_d;
          res_sat_d   = sat_q;
          state_d     = S_HOLD;
        end else begin
          scan_idx_d = scan_idx_q + IDX_WIDTH'(1);
        end
      end
      S_HOLD: begin
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '{default: '0};
      win_q       <= '0;
      sat_q       <= 1'b0;
      scan_idx_q  <= '0;
      max_q       <= '0;
      best_q      <= '0;
      tie_q       <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      res_digit_q <= '0;
      res_count_q <= '0;
      res_tie_q   <= 1'b0;
      res_none_q  <= 1'b0;
      res_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      sat_q       <= sat_d;
      scan_idx_q  <= scan_idx_d;
      max_q       <= max_d;
      best_q      <= best_d;
      tie_q       <= tie_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      res_digit_q <= res_digit_d;
      res_count_q <= res_count_d;
      res_tie_q   <= res_tie_d;
      res_none_q  <= res_none_d;
      res_sat_q   <= res_sat_d;
    end
  end

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign result_digit = res_digit_q;
  assign result_count = res_count_q;
  assign result_tie   = res_tie_q;
  assign result_none  = res_none_q;
  assign result_sat   = res_sat_q;

endmodule
